// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin front end that shares one combinational ALU
// between NUM_REQ requesters and returns a registered, tagged response.
//
// state   | meaning
// --------+-----------------------------------------------
// S_EMPTY | no response held, o_rsp_valid = 0
// S_FULL  | response held in r_rsp_*, o_rsp_valid = 1
module alu_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int CNT_W   = 16,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  output logic [NUM_REQ-1:0]          o_req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_op1,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_op2,
  input  logic [NUM_REQ*OP_W-1:0]     i_req_alu_op,
  output logic [DATA_W-1:0]           o_alu_op1,
  output logic [DATA_W-1:0]           o_alu_op2,
  output logic [OP_W-1:0]             o_alu_op,
  input  logic [DATA_W-1:0]           i_alu_result,
  input  logic                        i_alu_zero,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic [ID_W-1:0]             o_rsp_id,
  output logic [DATA_W-1:0]           o_rsp_result,
  output logic                        o_rsp_zero,
  output logic [CNT_W-1:0]            o_issue_count
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]        r_state;
  logic [ID_W-1:0]   r_last_grant;
  logic [ID_W-1:0]   r_rsp_id;
  logic [DATA_W-1:0] r_rsp_result;
  logic              r_rsp_zero;
  logic [CNT_W-1:0]  r_issue_count;

  logic [ID_W-1:0]   w_grant;
  logic              w_any;
  logic              w_can_accept;
  logic              w_accept;

  assign w_can_accept = (r_state == S_EMPTY) | i_rsp_ready;
  assign w_accept     = w_any & w_can_accept;

  // Round-robin search starting just after the last accepted requester.
  always_comb begin
    int idx;
    idx     = 0;
    w_grant = '0;
    w_any   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(r_last_grant) + k) % NUM_REQ;
      if (!w_any && i_req_valid[idx]) begin
        w_any   = 1'b1;
        w_grant = ID_W'(idx);
      end
    end
  end

  // One-hot ready to the granted requester only when the slot can take a result.
  always_comb begin
    o_req_ready = '0;
    if (w_accept) o_req_ready[w_grant] = 1'b1;
  end

  // Drive the ALU from the granted requester even while stalled, so the
  // operands are already settled when the response slot frees up.
  always_comb begin
    o_alu_op1 = '0;
    o_alu_op2 = '0;
    o_alu_op  = '0;
    if (w_any) begin
      o_alu_op1 = i_req_op1[int'(w_grant)*DATA_W +: DATA_W];
      o_alu_op2 = i_req_op2[int'(w_grant)*DATA_W +: DATA_W];
      o_alu_op  = i_req_alu_op[int'(w_grant)*OP_W +: OP_W];
    end
  end

  // Response slot, arbitration pointer and issue counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_EMPTY;
      r_last_grant  <= ID_W'(NUM_REQ - 1);
      r_rsp_id      <= '0;
      r_rsp_result  <= '0;
      r_rsp_zero    <= 1'b0;
      r_issue_count <= '0;
    end else if (w_accept) begin
      r_state       <= S_FULL;
      r_last_grant  <= w_grant;
      r_rsp_id      <= w_grant;
      r_rsp_result  <= i_alu_result;
      r_rsp_zero    <= i_alu_zero;
      r_issue_count <= r_issue_count + CNT_W'(1);
    end else if (i_rsp_ready) begin
      r_state       <= S_EMPTY;
    end
  end

  assign o_rsp_valid   = (r_state == S_FULL);
  assign o_rsp_id      = r_rsp_id;
  assign o_rsp_result  = r_rsp_result;
  assign o_rsp_zero    = r_rsp_zero;
  assign o_issue_count = r_issue_count;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: behavioural ALU, reference model with a
// response scoreboard, a vector table and directed corner sequences.
module tb_alu_rr_scheduler;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int OW = 4;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_op1;
  logic [N*DW-1:0] req_op2;
  logic [N*OW-1:0] req_alu_op;
  logic [DW-1:0]   alu_op1, alu_op2, alu_result;
  logic [OW-1:0]   alu_op;
  logic            alu_zero;
  logic            rsp_valid, rsp_ready, rsp_zero;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_result;
  logic [CW-1:0]   issue_count;

  logic [DW-1:0] op1 [N];
  logic [DW-1:0] op2 [N];
  logic [OW-1:0] aop [N];

  always #5 clk = ~clk;

  alu_rr_scheduler dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_op1(req_op1), .i_req_op2(req_op2), .i_req_alu_op(req_alu_op),
    .o_alu_op1(alu_op1), .o_alu_op2(alu_op2), .o_alu_op(alu_op),
    .i_alu_result(alu_result), .i_alu_zero(alu_zero),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_id(rsp_id), .o_rsp_result(rsp_result), .o_rsp_zero(rsp_zero),
    .o_issue_count(issue_count)
  );

  function automatic logic [DW-1:0] f_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [OW-1:0] op);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      default: return '0;
    endcase
  endfunction

  always_comb begin
    alu_result = f_alu(alu_op1, alu_op2, alu_op);
    alu_zero   = (alu_result == '0);
  end

  always_comb begin
    req_op1 = '0; req_op2 = '0; req_alu_op = '0;
    for (int i = 0; i < N; i++) begin
      req_op1[i*DW +: DW]    = op1[i];
      req_op2[i*DW +: DW]    = op2[i];
      req_alu_op[i*OW +: OW] = aop[i];
    end
  end

  typedef struct { logic [1:0] id; logic [DW-1:0] res; logic z; } rsp_t;
  rsp_t sb [$];

  int n_pass = 0;
  int n_total = 0;

  logic          m_valid;
  int            m_last;
  logic [CW-1:0] m_count;
  int            last_g;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    @(posedge clk);
    m_valid = 1'b0; m_last = N - 1; m_count = '0; sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock of stimulus: drive, check combinational outputs and the held
  // response against the model, then advance the model across the edge.
  task automatic cycle(input logic [N-1:0] v, input logic rr);
    logic can, any, acc;
    int g;
    rsp_t e;
    @(negedge clk);
    req_valid = v; rsp_ready = rr;
    #1;
    can = !m_valid || rr;
    any = 1'b0; g = 0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (!any && v[idx]) begin any = 1'b1; g = idx; end
    end
    acc = can && any;
    chk("req_ready", 64'(req_ready), acc ? 64'(1 << g) : 64'd0);
    chk("alu_op1", 64'(alu_op1), any ? 64'(op1[g]) : 64'd0);
    chk("alu_op", 64'(alu_op), any ? 64'(aop[g]) : 64'd0);
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    chk("issue_count", 64'(issue_count), 64'(m_count));
    if (m_valid && sb.size() > 0) begin
      chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
      chk("rsp_result", 64'(rsp_result), 64'(sb[0].res));
      chk("rsp_zero", 64'(rsp_zero), 64'(sb[0].z));
      if (rr) void'(sb.pop_front());
    end
    if (acc) begin
      e.id  = 2'(g);
      e.res = f_alu(op1[g], op2[g], aop[g]);
      e.z   = (e.res == '0);
      sb.push_back(e);
    end
    @(posedge clk);
    m_valid = acc || (m_valid && !rr);
    if (acc) begin m_last = g; m_count = m_count + 1'b1; last_g = g; end
    #1;
  endtask

  typedef struct {
    int id; logic [DW-1:0] a; logic [DW-1:0] b; logic [OW-1:0] op;
    logic [DW-1:0] res; logic z;
  } vec_t;
  vec_t vecs [7];

  initial begin
    vecs[0] = '{0, 32'd5,          32'd3,          4'd0, 32'd8,          1'b0};
    vecs[1] = '{1, 32'd10,         32'd3,          4'd1, 32'd7,          1'b0};
    vecs[2] = '{3, 32'h0000_F0F0,  32'h0000_0FF0,  4'd2, 32'h0000_00F0,  1'b0};
    vecs[3] = '{2, 32'd0,          32'd0,          4'd3, 32'd0,          1'b1};
    vecs[4] = '{1, 32'hAAAA_5555,  32'hFFFF_FFFF,  4'd4, 32'h5555_AAAA,  1'b0};
    vecs[5] = '{0, 32'd1,          32'd4,          4'd5, 32'd16,         1'b0};
    vecs[6] = '{3, 32'd3,          32'd3,          4'd9, 32'd0,          1'b1};

    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; last_g = 0;
    for (int i = 0; i < N; i++) begin op1[i] = 32'(i + 1); op2[i] = 32'(i); aop[i] = 4'd0; end
    do_reset();
    #1;
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_id", 64'(rsp_id), 64'd0);
    chk("reset rsp_result", 64'(rsp_result), 64'd0);
    chk("reset rsp_zero", 64'(rsp_zero), 64'd0);
    chk("reset issue_count", 64'(issue_count), 64'd0);

    // Single requester 2, 7 - 7.
    op1[2] = 32'd7; op2[2] = 32'd7; aop[2] = 4'b0001;
    cycle(4'b0100, 1'b1);
    chk("t1 rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1 rsp_id", 64'(rsp_id), 64'd2);
    chk("t1 rsp_result", 64'(rsp_result), 64'd0);
    chk("t1 rsp_zero", 64'(rsp_zero), 64'd1);

    // Vector table, one requester at a time.
    for (int t = 0; t < 7; t++) begin
      op1[vecs[t].id] = vecs[t].a; op2[vecs[t].id] = vecs[t].b; aop[vecs[t].id] = vecs[t].op;
      cycle(4'(1 << vecs[t].id), 1'b1);
      chk("vec rsp_id", 64'(rsp_id), 64'(vecs[t].id));
      chk("vec rsp_result", 64'(rsp_result), 64'(vecs[t].res));
      chk("vec rsp_zero", 64'(rsp_zero), 64'(vecs[t].z));
    end
    cycle(4'b0000, 1'b1);

    // Fairness with everyone valid.
    do_reset();
    for (int i = 0; i < N; i++) begin op1[i] = 32'(100 + i); op2[i] = 32'(i); aop[i] = 4'd0; end
    for (int t = 0; t < 6; t++) begin
      cycle(4'b1111, 1'b1);
      chk("rr rsp_id", 64'(rsp_id), 64'(t % N));
      chk("rr issue_count", 64'(issue_count), 64'(t + 1));
    end

    // Backpressure for 5 cycles, then release.
    for (int t = 0; t < 5; t++) begin
      cycle(4'b1111, 1'b0);
      chk("bp rsp_id", 64'(rsp_id), 64'd1);
      chk("bp issue_count", 64'(issue_count), 64'd6);
    end
    cycle(4'b1111, 1'b1);
    chk("bp release rsp_id", 64'(rsp_id), 64'd2);
    chk("bp release count", 64'(issue_count), 64'd7);

    // Wrap of the round-robin pointer past requester 3.
    do_reset();
    cycle(4'b0010, 1'b1);
    op1[1] = 32'hFFFF_FFFF; op2[1] = 32'd1; aop[1] = 4'd0;
    op1[3] = 32'hFFFF_FFFF; op2[3] = 32'd1; aop[3] = 4'd0;
    cycle(4'b1010, 1'b1);
    chk("wrap first id", 64'(rsp_id), 64'd3);
    chk("wrap result", 64'(rsp_result), 64'd0);
    chk("wrap zero", 64'(rsp_zero), 64'd1);
    cycle(4'b1010, 1'b1);
    chk("wrap second id", 64'(rsp_id), 64'd1);

    // Reset while a response is held.
    chk("pre-reset rsp_valid", 64'(rsp_valid), 64'd1);
    do_reset();
    #1;
    chk("mid reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid reset count", 64'(issue_count), 64'd0);
    cycle(4'b1111, 1'b1);
    chk("post reset grant", 64'(rsp_id), 64'd0);

    // Counter wrap.
    do_reset();
    for (int t = 0; t < 65535; t++) cycle(4'b1111, 1'b1);
    chk("count max", 64'(issue_count), 64'hFFFF);
    cycle(4'b1111, 1'b1);
    chk("count wrap 0", 64'(issue_count), 64'd0);
    cycle(4'b1111, 1'b1);
    chk("count wrap 1", 64'(issue_count), 64'd1);
    cycle(4'b0000, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
